// File: rtl/pixel_ray_issuer.sv
// rtl/pixel_ray_issuer.sv - raster pixel issuer with tag delay line and credit-limited ray FIFO
// Credits cover tags in flight plus buffered rays, so the FIFO can never overflow.
module pixel_ray_issuer #(
  parameter int H_RES   = 512,
  parameter int V_RES   = 384,
  parameter int LATENCY = 64,
  parameter int DEPTH   = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        issue_out,
  input  logic [31:0] dir_x_in,
  input  logic [31:0] dir_y_in,
  input  logic [31:0] dir_z_in,
  input  logic        dir_valid_in,
  output logic [31:0] ray_x_out,
  output logic [31:0] ray_y_out,
  output logic [31:0] ray_z_out,
  output logic [10:0] ray_px_out,
  output logic [9:0]  ray_py_out,
  output logic        ray_valid_out,
  input  logic        ray_ready_in,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        error_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] dz;
    logic [10:0] px;
    logic [9:0]  py;
  } ray_t;

  state_t          state_q, state_d;
  logic [10:0]     scan_x_q, scan_x_d;
  logic [9:0]      scan_y_q, scan_y_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            error_q;
  logic            dl_v_q [LATENCY];
  logic [10:0]     dl_x_q [LATENCY];
  logic [9:0]      dl_y_q [LATENCY];
  ray_t            mem_q  [DEPTH];

  logic            credit;
  logic            issue;
  logic            last_x;
  logic            last_y;
  logic            exit_v;
  logic            push;
  logic            pop;
  logic            frame_done;
  ray_t            head;

  assign credit = (32'(inflight_q) + 32'(count_q)) < DEPTH_U;
  assign issue  = (state_q == S_ISSUE) && credit;
  assign last_x = (scan_x_q == 11'(H_RES - 1));
  assign last_y = (scan_y_q == 10'(V_RES - 1));
  assign exit_v = dl_v_q[LATENCY-1];
  assign push   = exit_v && dir_valid_in;
  assign pop    = (count_q != '0) && ray_ready_in;

  always_comb begin
    state_d    = state_q;
    scan_x_d   = scan_x_q;
    scan_y_d   = scan_y_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d  = S_ISSUE;
          scan_x_d = '0;
          scan_y_d = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          if (last_x) begin
            scan_x_d = '0;
            if (last_y) begin
              scan_y_d = '0;
              state_d  = S_DRAIN;
            end else begin
              scan_y_d = scan_y_q + 10'd1;
            end
          end else begin
            scan_x_d = scan_x_q + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 && count_q == '0) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, exit_v})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      scan_x_q   <= '0;
      scan_y_q   <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_x_q   <= scan_x_d;
      scan_y_q   <= scan_y_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (exit_v && !dir_valid_in) error_q <= 1'b1;
    end
  end

  // Only the valid bits need clearing; stale coordinates behind a cleared bit are harmless.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < LATENCY; i++) dl_v_q[i] <= 1'b0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) dl_v_q[i] <= dl_v_q[i-1];
      dl_v_q[0] <= issue;
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = LATENCY - 1; i > 0; i--) begin
      dl_x_q[i] <= dl_x_q[i-1];
      dl_y_q[i] <= dl_y_q[i-1];
    end
    dl_x_q[0] <= scan_x_q;
    dl_y_q[0] <= scan_y_q;
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{dx: dir_x_in, dy: dir_y_in, dz: dir_z_in,
                           px: dl_x_q[LATENCY-1], py: dl_y_q[LATENCY-1]};
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign ray_valid_out  = (count_q != '0);
  assign ray_x_out      = ray_valid_out ? head.dx : '0;
  assign ray_y_out      = ray_valid_out ? head.dy : '0;
  assign ray_z_out      = ray_valid_out ? head.dz : '0;
  assign ray_px_out     = ray_valid_out ? head.px : '0;
  assign ray_py_out     = ray_valid_out ? head.py : '0;

  assign x_out          = scan_x_q;
  assign y_out          = scan_y_q;
  assign issue_out      = issue;
  assign busy_out       = (state_q != S_IDLE);
  assign frame_done_out = frame_done;
  assign error_out      = error_q;

endmodule
